cluster_unpacker: RTL and testbench

CLUSTER_UNPACKER -- requirements
Module: cluster_unpacker

---
 rtl/cluster_pkg.sv | 30 +++
 rtl/cluster_expander.sv | 34 +++
 rtl/cluster_unpacker.sv | 183 ++++++++++++++++++
 tb/tb_cluster_unpacker.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
// Shared constants, cluster-word field layout and FSM state type for the
// cluster unpacker.
package cluster_pkg;

    localparam int NUM_CLUSTERS = 8;
    localparam int NUM_SBITS    = 1536;
    localparam int CNT_BITS     = 3;
    localparam int ADR_BITS     = 11;
    localparam int WORD_BITS    = CNT_BITS + ADR_BITS;
    localparam int ADR_LSB      = 0;
    localparam int ADR_MSB      = ADR_LSB + ADR_BITS - 1;
    localparam int CNT_LSB      = ADR_MSB + 1;
    localparam int CNT_MSB      = CNT_LSB + CNT_BITS - 1;
    localparam int PHASE_BITS   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [ADR_BITS-1:0] word_adr(input logic [WORD_BITS-1:0] w);
        return w[ADR_MSB:ADR_LSB];
    endfunction

    function automatic logic [CNT_BITS-1:0] word_cnt(input logic [WORD_BITS-1:0] w);
        return w[CNT_MSB:CNT_LSB];
    endfunction

endpackage

// File: rtl/cluster_expander.sv
// Combinational expansion of one cluster word into a strip mask; strips past
// the top of the map are truncated, and null addresses produce no bits.
module cluster_expander
    import cluster_pkg::*;
#(
    parameter int SBITS = NUM_SBITS
) (
    input  logic [WORD_BITS-1:0] word_i,
    output logic [SBITS-1:0]     mask_o,
    output logic                 valid_o
);

    localparam int RUN_BITS = 1 << CNT_BITS;

    logic [ADR_BITS-1:0] adr_s;
    logic [CNT_BITS-1:0] cnt_s;
    logic [RUN_BITS-1:0] run_s;
    logic [SBITS-1:0]    base_s;

    // Build a run of cnt+1 ones (~cnt is 7-cnt) and slide it up to the first strip
    always_comb begin
        adr_s   = word_adr(word_i);
        cnt_s   = word_cnt(word_i);
        run_s   = {RUN_BITS{1'b1}} >> (~cnt_s);
        base_s  = {{(SBITS-RUN_BITS){1'b0}}, run_s};
        valid_o = (int'(adr_s) < SBITS);
        if (valid_o) begin
            mask_o = base_s << adr_s;
        end else begin
            mask_o = '0;
        end
    end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the per-frame s-bit map from eight cluster words, two words per
// cycle over four expansion phases, with back-to-back frame acceptance.
module cluster_unpacker #(
    parameter int NUM_CLUSTERS = cluster_pkg::NUM_CLUSTERS,
    parameter int NUM_SBITS    = cluster_pkg::NUM_SBITS
) (
    input  logic                            clock4x,
    input  logic                            global_reset_n,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster0,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster1,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster2,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster3,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster4,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster5,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster6,
    input  logic [cluster_pkg::WORD_BITS-1:0] cluster7,
    input  logic                            frame_strobe,
    output logic [NUM_SBITS-1:0]            sbits,
    output logic                            sbits_valid,
    output logic [3:0]                      cluster_count,
    output logic [7:0]                      overflow_cnt,
    output logic                            busy
);

    import cluster_pkg::*;

    localparam logic [PHASE_BITS-1:0] LAST_PHASE = 2'd3;

    state_e                state_q, state_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic                  accept_s, drop_s, finish_s;

    logic [WORD_BITS-1:0]  words_q [NUM_CLUSTERS];
    logic [NUM_SBITS-1:0]  acc_q, merged_s, mask_a_s, mask_b_s, sbits_q;
    logic [3:0]            acc_cnt_q, merged_cnt_s, cnt_q;
    logic                  valid_a_s, valid_b_s;
    logic [2:0]            slot_a_s, slot_b_s;
    logic [7:0]            ovf_q;
    logic                  valid_q, busy_q, ready_q;

    assign slot_a_s = {phase_q, 1'b0};
    assign slot_b_s = {phase_q, 1'b1};

    cluster_expander #(.SBITS(NUM_SBITS)) u_expand_a (
        .word_i  (words_q[slot_a_s]),
        .mask_o  (mask_a_s),
        .valid_o (valid_a_s)
    );

    cluster_expander #(.SBITS(NUM_SBITS)) u_expand_b (
        .word_i  (words_q[slot_b_s]),
        .mask_o  (mask_b_s),
        .valid_o (valid_b_s)
    );

    // Next state: a strobe is taken when idle, in the last phase or in DONE, dropped otherwise
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        accept_s = 1'b0;
        drop_s   = 1'b0;
        finish_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_strobe && ready_q) begin
                    accept_s = 1'b1;
                    state_d  = ST_EXPAND;
                    phase_d  = 2'd0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (phase_q == LAST_PHASE) begin
                    finish_s = 1'b1;
                    phase_d  = 2'd0;
                    if (frame_strobe) begin
                        accept_s = 1'b1;
                        state_d  = ST_EXPAND;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                    drop_s  = frame_strobe;
                end
            end
            ST_DONE: begin
                phase_d = 2'd0;
                if (frame_strobe) begin
                    accept_s = 1'b1;
                    state_d  = ST_EXPAND;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 2'd0;
            end
        endcase
    end

    // FSM state and phase registers
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Accumulator including the pair being expanded this phase
    always_comb begin
        merged_s     = acc_q | mask_a_s | mask_b_s;
        merged_cnt_s = acc_cnt_q + {3'b000, valid_a_s} + {3'b000, valid_b_s};
    end

    // Input capture and accumulation
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int k = 0; k < NUM_CLUSTERS; k++) begin
                words_q[k] <= '0;
            end
            acc_q     <= '0;
            acc_cnt_q <= 4'd0;
        end else if (accept_s) begin
            words_q[0] <= cluster0;
            words_q[1] <= cluster1;
            words_q[2] <= cluster2;
            words_q[3] <= cluster3;
            words_q[4] <= cluster4;
            words_q[5] <= cluster5;
            words_q[6] <= cluster6;
            words_q[7] <= cluster7;
            acc_q      <= '0;
            acc_cnt_q  <= 4'd0;
        end else if (state_q == ST_EXPAND) begin
            acc_q     <= merged_s;
            acc_cnt_q <= merged_cnt_s;
        end else begin
            acc_q     <= acc_q;
            acc_cnt_q <= acc_cnt_q;
        end
    end

    // Registered outputs; the map is loaded as the last phase closes so it is valid during DONE
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            sbits_q <= '0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 8'd0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            busy_q  <= (state_d == ST_EXPAND);
            valid_q <= finish_s;
            if (finish_s) begin
                sbits_q <= merged_s;
                cnt_q   <= merged_cnt_s;
            end else begin
                sbits_q <= sbits_q;
                cnt_q   <= cnt_q;
            end
            if (drop_s && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end else begin
                ovf_q <= ovf_q;
            end
        end
    end

    assign sbits         = sbits_q;
    assign sbits_valid   = valid_q;
    assign cluster_count = cnt_q;
    assign overflow_cnt  = ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
// Self-checking bench for cluster_unpacker: directed frames plus randomized
// strobes checked against a strip-level reference model.
module tb_cluster_unpacker;

    localparam int NS = 1536;
    localparam logic [13:0] NULLW = 14'h07FF;

    logic          clock4x = 1'b0;
    logic          global_reset_n;
    logic [13:0]   cluster0, cluster1, cluster2, cluster3;
    logic [13:0]   cluster4, cluster5, cluster6, cluster7;
    logic          frame_strobe;
    logic [NS-1:0] sbits;
    logic          sbits_valid;
    logic [3:0]    cluster_count;
    logic [7:0]    overflow_cnt;
    logic          busy;

    always #5 clock4x = ~clock4x;

    cluster_unpacker dut (
        .clock4x(clock4x), .global_reset_n(global_reset_n),
        .cluster0(cluster0), .cluster1(cluster1), .cluster2(cluster2), .cluster3(cluster3),
        .cluster4(cluster4), .cluster5(cluster5), .cluster6(cluster6), .cluster7(cluster7),
        .frame_strobe(frame_strobe), .sbits(sbits), .sbits_valid(sbits_valid),
        .cluster_count(cluster_count), .overflow_cnt(overflow_cnt), .busy(busy)
    );

    typedef struct {
        int            due;
        logic [NS-1:0] map;
        int            cnt;
    } exp_t;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            last_acc = -100;
    int            ready_cyc = 0;
    int            exp_ovf = 0;
    int            exp_cnt = 0;
    logic          exp_valid = 1'b0;
    logic          exp_busy = 1'b0;
    logic [NS-1:0] exp_map = '0;
    logic [13:0]   fw [8];
    exp_t          pend_q[$];

    // Reference: set every strip from adr to adr+cnt that lies inside the map
    function automatic logic [NS-1:0] ref_map();
        logic [NS-1:0] m;
        int adr, last;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            adr  = int'(fw[k][10:0]);
            last = adr + int'(fw[k][13:11]);
            for (int s = adr; s <= last; s++) begin
                if (s < NS) m[s] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic int ref_cnt();
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (int'(fw[k][10:0]) < NS) n++;
        end
        return n;
    endfunction

    function automatic logic [13:0] rand_word();
        logic [10:0] a;
        logic [2:0]  c;
        c = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: a = 11'($urandom_range(1536, 2047));
            1: a = 11'($urandom_range(1528, 1535));
            2: a = 11'($urandom_range(60, 66));
            default: a = 11'($urandom_range(0, 1535));
        endcase
        return {c, a};
    endfunction

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) fw[k] = rand_word();
    endtask

    // One clock: a frame is taken only if 4 cycles have passed since the last one taken
    task automatic tick(input logic strb);
        exp_t e;
        {cluster0, cluster1, cluster2, cluster3} = {fw[0], fw[1], fw[2], fw[3]};
        {cluster4, cluster5, cluster6, cluster7} = {fw[4], fw[5], fw[6], fw[7]};
        frame_strobe = strb;
        if (strb && cyc >= ready_cyc) begin
            if (cyc >= last_acc + 4) begin
                last_acc = cyc;
                e.due = cyc + 5;
                e.map = ref_map();
                e.cnt = ref_cnt();
                pend_q.push_back(e);
            end else if (exp_ovf < 255) begin
                exp_ovf++;
            end
        end
        @(posedge clock4x);
        cyc++;
        @(negedge clock4x);
        frame_strobe = 1'b0;
        exp_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            exp_valid = 1'b1;
            exp_map   = pend_q[0].map;
            exp_cnt   = pend_q[0].cnt;
            void'(pend_q.pop_front());
        end
        exp_busy = (cyc >= last_acc + 1) && (cyc <= last_acc + 4);
    endtask

    task automatic apply_reset();
        global_reset_n = 1'b0;
        pend_q.delete();
        last_acc = -100;
        exp_ovf = 0; exp_cnt = 0; exp_map = '0; exp_valid = 1'b0; exp_busy = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) begin
            @(posedge clock4x);
            cyc++;
        end
        @(negedge clock4x);
        global_reset_n = 1'b1;
        ready_cyc = cyc + 1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) fw[k] = NULLW;
        frame_strobe = 1'b0;
        global_reset_n = 1'b1;
        #2;
        apply_reset();
        vectors += 5;
        if (sbits !== '0) begin miscompares++; $display("FAIL reset_sbits got_ones=%0d want_ones=0", $countones(sbits)); end
        if (sbits_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", sbits_valid); end
        if (cluster_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", cluster_count); end
        if (overflow_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_ovf got=%0d want=0", overflow_cnt); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        release_reset();
        repeat (2) begin
            tick(1'b0);
            vectors++;
            if (sbits_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++; $display("FAIL reset_idle valid=%b busy=%b want 0/0", sbits_valid, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [NS-1:0] want;
        want = '0;
        want[7:0] = 8'hFF;
        fw[0] = {3'd7, 11'd0};
        for (int k = 1; k < 8; k++) fw[k] = NULLW;
        tick(1'b1);
        for (int t = 1; t <= 7; t++) begin
            vectors++;
            if (sbits_valid !== (t == 5)) begin
                miscompares++; $display("FAIL single_valid cycle=%0d got=%b want=%b", t, sbits_valid, (t == 5));
            end
            if (t == 5) begin
                vectors += 2;
                if (sbits !== want) begin miscompares++; $display("FAIL single_map got_ones=%0d got_low=%h want_low=ff", $countones(sbits), sbits[15:0]); end
                if (cluster_count !== 4'd1) begin miscompares++; $display("FAIL single_count got=%0d want=1", cluster_count); end
            end
            tick(1'b0);
        end
    endtask

    task automatic test_edge_crossing();
        logic [NS-1:0] want;
        want = '0;
        want[1534] = 1'b1; want[1535] = 1'b1; want[63] = 1'b1; want[64] = 1'b1;
        fw[0] = {3'd3, 11'd1534};
        fw[1] = {3'd1, 11'd63};
        for (int k = 2; k < 8; k++) fw[k] = NULLW;
        tick(1'b1);
        for (int t = 1; t <= 6; t++) begin
            vectors++;
            if (sbits_valid !== (t == 5)) begin
                miscompares++; $display("FAIL edge_valid cycle=%0d got=%b want=%b", t, sbits_valid, (t == 5));
            end
            if (t == 5) begin
                vectors += 2;
                if (sbits !== want) begin miscompares++; $display("FAIL edge_map got_ones=%0d want_ones=4 b63=%b b64=%b b1535=%b", $countones(sbits), sbits[63], sbits[64], sbits[1535]); end
                if (cluster_count !== 4'd2) begin miscompares++; $display("FAIL edge_count got=%0d want=2", cluster_count); end
            end
            tick(1'b0);
        end
    endtask

    task automatic test_all_null();
        for (int k = 0; k < 8; k++) fw[k] = NULLW;
        tick(1'b1);
        for (int t = 1; t <= 6; t++) begin
            vectors++;
            if (sbits_valid !== (t == 5)) begin
                miscompares++; $display("FAIL null_valid cycle=%0d got=%b want=%b", t, sbits_valid, (t == 5));
            end
            if (t == 5) begin
                vectors += 2;
                if (sbits !== '0) begin miscompares++; $display("FAIL null_map got_ones=%0d want_ones=0", $countones(sbits)); end
                if (cluster_count !== 4'd0) begin miscompares++; $display("FAIL null_count got=%0d want=0", cluster_count); end
            end
            tick(1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int start, seen;
        start = cyc;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            if (t == 0 || t == 4) rand_frame();
            tick(t == 0 || t == 4);
            vectors++;
            if (sbits_valid !== ((cyc - start) == 5 || (cyc - start) == 9)) begin
                miscompares++; $display("FAIL b2b_valid cycle=%0d got=%b", cyc - start, sbits_valid);
            end
            if (sbits_valid === 1'b1) seen++;
            vectors += 2;
            if (sbits !== exp_map) begin miscompares++; $display("FAIL b2b_map cycle=%0d got_ones=%0d want_ones=%0d", cyc - start, $countones(sbits), $countones(exp_map)); end
            if (cluster_count !== 4'(exp_cnt)) begin miscompares++; $display("FAIL b2b_count cycle=%0d got=%0d want=%0d", cyc - start, cluster_count, exp_cnt); end
        end
        vectors += 2;
        if (seen != 2) begin miscompares++; $display("FAIL b2b_pulses got=%0d want=2", seen); end
        if (overflow_cnt !== 8'd0) begin miscompares++; $display("FAIL b2b_ovf got=%0d want=0", overflow_cnt); end
    endtask

    task automatic test_overflow();
        logic [NS-1:0] first_map;
        rand_frame();
        first_map = ref_map();
        for (int t = 0; t < 8; t++) begin
            if (t == 2) rand_frame();
            tick(t == 0 || t == 2);
            vectors++;
            if (sbits_valid !== (t == 4)) begin
                miscompares++; $display("FAIL ovf_valid cycle=%0d got=%b want=%b", t + 1, sbits_valid, (t == 4));
            end
            if (t == 4) begin
                vectors++;
                if (sbits !== first_map) begin miscompares++; $display("FAIL ovf_map got_ones=%0d want_ones=%0d", $countones(sbits), $countones(first_map)); end
            end
        end
        vectors++;
        if (overflow_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_one got=%0d want=1", overflow_cnt); end
        for (int n = 0; n < 300; n++) begin
            for (int t = 0; t < 4; t++) begin
                if (t == 0) rand_frame();
                tick(t == 0 || t == 2);
                vectors++;
                if (sbits_valid !== exp_valid || overflow_cnt !== 8'(exp_ovf)) begin
                    miscompares++; $display("FAIL ovf_run n=%0d valid=%b/%b ovf=%0d/%0d", n, sbits_valid, exp_valid, overflow_cnt, exp_ovf);
                end
            end
        end
        repeat (6) tick(1'b0);
        vectors++;
        if (overflow_cnt !== 8'd255) begin miscompares++; $display("FAIL ovf_saturate got=%0d want=255", overflow_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        rand_frame();
        tick(1'b1);
        tick(1'b0);
        apply_reset();
        vectors += 5;
        if (sbits !== '0) begin miscompares++; $display("FAIL rstmid_sbits got_ones=%0d want_ones=0", $countones(sbits)); end
        if (sbits_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got=%b want=0", sbits_valid); end
        if (cluster_count !== 4'd0) begin miscompares++; $display("FAIL rstmid_count got=%0d want=0", cluster_count); end
        if (overflow_cnt !== 8'd0) begin miscompares++; $display("FAIL rstmid_ovf got=%0d want=0", overflow_cnt); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        release_reset();
        for (int t = 0; t < 6; t++) begin
            tick(1'b0);
            vectors++;
            if (sbits_valid !== 1'b0 || sbits !== '0) begin
                miscompares++; $display("FAIL rstmid_stale valid=%b ones=%0d want 0/0", sbits_valid, $countones(sbits));
            end
        end
        rand_frame();
        tick(1'b1);
        for (int t = 1; t <= 6; t++) begin
            vectors++;
            if (sbits_valid !== (t == 5)) begin
                miscompares++; $display("FAIL rstmid_next_valid cycle=%0d got=%b want=%b", t, sbits_valid, (t == 5));
            end
            if (t == 5) begin
                vectors++;
                if (sbits !== exp_map) begin miscompares++; $display("FAIL rstmid_next_map got_ones=%0d want_ones=%0d", $countones(sbits), $countones(exp_map)); end
            end
            tick(1'b0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 500; t++) begin
            rand_frame();
            tick($urandom_range(0, 9) < 4);
            vectors += 5;
            if (sbits_valid !== exp_valid) begin miscompares++; $display("FAIL rand_valid cycle=%0d got=%b want=%b", cyc, sbits_valid, exp_valid); end
            if (sbits !== exp_map) begin miscompares++; $display("FAIL rand_map cycle=%0d got_ones=%0d want_ones=%0d", cyc, $countones(sbits), $countones(exp_map)); end
            if (cluster_count !== 4'(exp_cnt)) begin miscompares++; $display("FAIL rand_count cycle=%0d got=%0d want=%0d", cyc, cluster_count, exp_cnt); end
            if (overflow_cnt !== 8'(exp_ovf)) begin miscompares++; $display("FAIL rand_ovf cycle=%0d got=%0d want=%0d", cyc, overflow_cnt, exp_ovf); end
            if (busy !== exp_busy) begin miscompares++; $display("FAIL rand_busy cycle=%0d got=%b want=%b", cyc, busy, exp_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_edge_crossing();
        test_all_null();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
